// File: rtl/multiplicador_pkg.sv
// Shared definitions for the sequential matrix multiplier: controller state
// encoding and the helper that sizes the i/j/k index counters.
package multiplicador_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that walks 0..n-1; never narrower than one bit so
    // that degenerate dimensions of size 1 still get a real register.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Index widths for the default 2x4 * 4x2 configuration.
    localparam int M_DEF  = 4;
    localparam int N_DEF  = 2;
    localparam int P_DEF  = 2;
    localparam int KW_DEF = idx_width(M_DEF);
    localparam int IW_DEF = idx_width(N_DEF);
    localparam int JW_DEF = idx_width(P_DEF);

endpackage

// File: rtl/multiplicador_mac.sv
// One multiply-accumulate step: both operands are widened to the result width
// (sign- or zero-extended), multiplied, and added to the running sum. All
// arithmetic wraps modulo 2^EBit, which equals extending the full product.
module multiplicador_mac #(
    parameter int Bit    = 3,
    parameter int EBit   = 2*Bit+2,
    parameter bit SIGNED = 1'b0
) (
    input  logic [Bit-1:0]  a_i,
    input  logic [Bit-1:0]  b_i,
    input  logic [EBit-1:0] acc_i,
    output logic [EBit-1:0] sum_o
);

    logic [EBit-1:0] aExt;
    logic [EBit-1:0] bExt;
    logic [EBit-1:0] prod;

    // Widen the operands, then form the single product and the wrapping sum.
    always_comb begin
        if (SIGNED) begin
            aExt = EBit'($signed(a_i));
            bExt = EBit'($signed(b_i));
        end else begin
            aExt = EBit'(a_i);
            bExt = EBit'(b_i);
        end
        prod  = aExt * bExt;
        sum_o = acc_i + prod;
    end

endmodule

// File: rtl/multiplicador_seq.sv
// Sequential matrix multiplier C = A * B using a single MAC unit. One MAC is
// performed per RUN cycle; finished elements go to an internal buffer and the
// whole buffer is published on out only when the last element completes.
module multiplicador_seq
    import multiplicador_pkg::*;
#(
    parameter int Bit    = 3,
    parameter int EBit   = 2*Bit+2,
    parameter int M      = 4,
    parameter int N      = 2,
    parameter int P      = 2,
    parameter bit SIGNED = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [N*M*Bit-1:0]    in1,
    input  logic [M*P*Bit-1:0]    in2,
    output logic                  busy,
    output logic                  done,
    output logic [N*P*EBit-1:0]   out
);

    localparam int KW = idx_width(M);
    localparam int IW = idx_width(N);
    localparam int JW = idx_width(P);

    localparam logic [KW-1:0] KLAST = KW'(M-1);
    localparam logic [IW-1:0] ILAST = IW'(N-1);
    localparam logic [JW-1:0] JLAST = JW'(P-1);

    state_t stateQ;

    // Operand copies taken at acceptance, so later input changes are harmless.
    logic [Bit-1:0]  aQ   [N][M];
    logic [Bit-1:0]  bQ   [M][P];
    logic [EBit-1:0] bufQ [N][P];

    logic [IW-1:0]        iQ;
    logic [JW-1:0]        jQ;
    logic [KW-1:0]        kQ;
    logic [EBit-1:0]      accQ;
    logic [N*P*EBit-1:0]  outQ;
    logic                 busyQ;
    logic                 doneQ;

    logic [Bit-1:0]  aCur;
    logic [Bit-1:0]  bCur;
    logic [EBit-1:0] accD;

    // Select A[i][k] and B[k][j] with constant-index compares so any
    // dimension (including non-powers of two) maps cleanly onto the counters.
    always_comb begin
        aCur = '0;
        bCur = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < M; k++) begin
                if (iQ == IW'(i) && kQ == KW'(k)) begin
                    aCur = aQ[i][k];
                end
            end
        end
        for (int k = 0; k < M; k++) begin
            for (int j = 0; j < P; j++) begin
                if (kQ == KW'(k) && jQ == JW'(j)) begin
                    bCur = bQ[k][j];
                end
            end
        end
    end

    multiplicador_mac #(
        .Bit    (Bit),
        .EBit   (EBit),
        .SIGNED (SIGNED)
    ) u_mac (
        .a_i   (aCur),
        .b_i   (bCur),
        .acc_i (accQ),
        .sum_o (accD)
    );

    // Controller and datapath registers: accept, iterate i/j/k, publish, return.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateQ <= IDLE;
            iQ     <= '0;
            jQ     <= '0;
            kQ     <= '0;
            accQ   <= '0;
            outQ   <= '0;
            busyQ  <= 1'b0;
            doneQ  <= 1'b0;
            for (int i = 0; i < N; i++) begin
                for (int k = 0; k < M; k++) begin
                    aQ[i][k] <= '0;
                end
                for (int j = 0; j < P; j++) begin
                    bufQ[i][j] <= '0;
                end
            end
            for (int k = 0; k < M; k++) begin
                for (int j = 0; j < P; j++) begin
                    bQ[k][j] <= '0;
                end
            end
        end else begin
            case (stateQ)
                IDLE: begin
                    doneQ <= 1'b0;
                    if (start) begin
                        for (int i = 0; i < N; i++) begin
                            for (int k = 0; k < M; k++) begin
                                aQ[i][k] <= in1[(i*M + k)*Bit +: Bit];
                            end
                        end
                        for (int k = 0; k < M; k++) begin
                            for (int j = 0; j < P; j++) begin
                                bQ[k][j] <= in2[(j*M + k)*Bit +: Bit];
                            end
                        end
                        iQ     <= '0;
                        jQ     <= '0;
                        kQ     <= '0;
                        accQ   <= '0;
                        busyQ  <= 1'b1;
                        stateQ <= RUN;
                    end
                end

                RUN: begin
                    if (kQ == KLAST) begin
                        for (int i = 0; i < N; i++) begin
                            for (int j = 0; j < P; j++) begin
                                if (iQ == IW'(i) && jQ == JW'(j)) begin
                                    bufQ[i][j] <= accD;
                                end
                            end
                        end
                        accQ <= '0;
                        kQ   <= '0;
                        if (jQ == JLAST) begin
                            jQ <= '0;
                            if (iQ == ILAST) begin
                                iQ     <= '0;
                                doneQ  <= 1'b1;
                                stateQ <= DONE;
                                for (int i = 0; i < N; i++) begin
                                    for (int j = 0; j < P; j++) begin
                                        if (iQ == IW'(i) && jQ == JW'(j)) begin
                                            outQ[(i*P + j)*EBit +: EBit] <= accD;
                                        end else begin
                                            outQ[(i*P + j)*EBit +: EBit] <= bufQ[i][j];
                                        end
                                    end
                                end
                            end else begin
                                iQ <= iQ + IW'(1);
                            end
                        end else begin
                            jQ <= jQ + JW'(1);
                        end
                    end else begin
                        accQ <= accD;
                        kQ   <= kQ + KW'(1);
                    end
                end

                DONE: begin
                    doneQ  <= 1'b0;
                    busyQ  <= 1'b0;
                    stateQ <= IDLE;
                end

                default: begin
                    doneQ  <= 1'b0;
                    busyQ  <= 1'b0;
                    stateQ <= IDLE;
                end
            endcase
        end
    end

    assign busy = busyQ;
    assign done = doneQ;
    assign out  = outQ;

endmodule

// File: doc/multiplicador_seq.md
MULTIPLICADOR_SEQ -- requirements
Module: multiplicador_seq

Interface
REQ-001 The block SHALL have parameter Bit, default 3, meaning the operand element width in bits.
REQ-002 The block SHALL have parameter EBit, default 2*Bit+2, meaning the result element width in bits.
REQ-003 The block SHALL have parameter M, default 4, meaning the inner dimension (columns of A, rows of B).
REQ-004 The block SHALL have parameter N, default 2, meaning the rows of A and of the result.
REQ-005 The block SHALL have parameter P, default 2, meaning the columns of B and of the result.
REQ-006 The block SHALL have parameter SIGNED, default 0, meaning 0 = unsigned elements and 1 = two's-complement elements.
REQ-007 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-008 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-009 The block SHALL have port start, input, 1 bit: request to begin a multiplication.
REQ-010 The block SHALL have port in1, input, N*M*Bit bits: matrix A, element A[i][k] at bits [i*M*Bit + k*Bit +: Bit].
REQ-011 The block SHALL have port in2, input, M*P*Bit bits: matrix B column-major, element B[k][j] at bits [j*M*Bit + k*Bit +: Bit].
REQ-012 The block SHALL have port busy, output, 1 bit: high from start acceptance through the DONE cycle.
REQ-013 The block SHALL have port done, output, 1 bit: single-cycle pulse marking that out is updated.
REQ-014 The block SHALL have port out, output, N*P*EBit bits: result matrix, element C[i][j] at bits [(i*P + j)*EBit +: EBit].

Function
REQ-015 The control FSM SHALL have exactly the states IDLE, RUN and DONE.
REQ-016 In IDLE, start=1 SHALL be accepted at the clock edge: in1 and in2 are captured into internal registers, the indices are set to i=j=k=0, the accumulator is cleared, and the next state is RUN.
REQ-017 start SHALL be ignored in RUN and in DONE; input changes after acceptance SHALL NOT affect the result.
REQ-018 Each RUN cycle SHALL perform one MAC, acc += A[i][k]*B[k][j], where the product and the sum are sign- or zero-extended to EBit per SIGNED and wrap modulo 2^EBit.
REQ-019 When k=M-1, the MAC result SHALL be written to internal result buffer slot (i,j), acc SHALL be cleared, and k SHALL wrap to 0.
REQ-020 On that k wrap, j SHALL increment, and i SHALL increment when j wraps from P-1.
REQ-021 After the MAC for (N-1,P-1,M-1), the FSM SHALL enter DONE and the whole result buffer SHALL be copied to out at that same edge.
REQ-022 done SHALL be 1 only in DONE, exactly N*P*M clock edges after the accepting edge.
REQ-023 DONE SHALL always return to IDLE at the next edge, so start is accepted no earlier than one cycle after done.
REQ-024 out SHALL hold its last value from done until the next done; partial results SHALL never be visible on out.
REQ-025 busy SHALL equal (state != IDLE).
REQ-026 The degenerate case M=1 SHALL take N*P RUN cycles with no special-casing.

Reset
REQ-027 rst_n=0 SHALL immediately, without waiting for a clock edge, force state IDLE, busy=0, done=0, out=0, acc=0, indices=0 and the result buffer to 0.
REQ-028 A reset asserted during RUN or DONE SHALL abort the operation, and no done pulse SHALL follow.
REQ-029 After rst_n is released, the first edge with start=1 SHALL be accepted normally.

Structure
REQ-030 The FSM state encoding and the index-width constants ($clog2 of M, N and P, minimum 1) SHALL live in the shared package multiplicador_pkg.
REQ-031 The multiply-accumulate datapath (extension, product and wrap-around add) SHALL be the single sub-module multiplicador_mac, parameterised by Bit, EBit and SIGNED.
REQ-032 There SHALL be one multiplier instance only; the block SHALL NOT use parallel multipliers.

Verification (Bit=3, M=4, N=2, P=2, EBit=8 unless stated)
REQ-033 SIGNED=0, all elements 1, start for 1 cycle -> done exactly 16 edges later, every C element = 4, busy high for 17 cycles.
REQ-034 SIGNED=0, all elements 7 -> every C element = 196 (0xC4); then A = identity-like rows {1,0,0,0},{0,1,0,0} with B columns {2,3,4,5},{6,7,0,1} -> C[0][0]=2, C[0][1]=6, C[1][0]=3, C[1][1]=7.
REQ-035 SIGNED=1, all elements -4 -> every C element = 64 (0x40); all A = -1 and all B = 3 -> every element = -12 (0xF4).
REQ-036 start held high continuously -> each operation is accepted only in IDLE, done pulses every 18 cycles, and toggling in1 during RUN leaves the result unchanged.
REQ-037 rst_n pulsed low at cycle 7 of RUN -> out=0, busy=0 asynchronously, no done; a new start afterwards produces the correct result.
REQ-038 N=3, P=1, M=2 build -> out packing per REQ-014 is checked against a reference model with random operands for 200 operations.
